// File: rtl/pmt_inverse_com.sv
// Inverse pivot permutation: restores four permuted complex channels to natural order.
// Define PMT_INV_DBG_EN to expose the internal sel register on sel_dbg.
module pmt_inverse_com #(
    parameter int DATA_WIDTH    = 16,
    parameter int WIDTH_COUNTER = 2,
    parameter int FLAG_COUNTER  = 1,
    parameter int LOWER         = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_in,
    input  logic [DATA_WIDTH-1:0] x_a_in,
    input  logic [DATA_WIDTH-1:0] y_a_in,
    input  logic [DATA_WIDTH-1:0] x_b_in,
    input  logic [DATA_WIDTH-1:0] y_b_in,
    input  logic [DATA_WIDTH-1:0] x_c_in,
    input  logic [DATA_WIDTH-1:0] y_c_in,
    input  logic [DATA_WIDTH-1:0] x_d_in,
    input  logic [DATA_WIDTH-1:0] y_d_in,
    output logic [DATA_WIDTH-1:0] x_a_out,
    output logic [DATA_WIDTH-1:0] y_a_out,
    output logic [DATA_WIDTH-1:0] x_b_out,
    output logic [DATA_WIDTH-1:0] y_b_out,
    output logic [DATA_WIDTH-1:0] x_c_out,
    output logic [DATA_WIDTH-1:0] y_c_out,
    output logic [DATA_WIDTH-1:0] x_d_out,
    output logic [DATA_WIDTH-1:0] y_d_out,
    output logic                  ctrl_out
`ifdef PMT_INV_DBG_EN
    ,
    output logic [1:0]            sel_dbg
`endif
);

    localparam logic [1:0] SEL_00 = 2'b00;
    localparam logic [1:0] SEL_01 = 2'b01;
    localparam logic [1:0] SEL_11 = 2'b11;
    localparam logic [1:0] SEL_10 = 2'b10;

    logic [1:0]               sel_q, sel_d;
    logic                     proc_start_q, proc_start_d;
    logic [WIDTH_COUNTER-1:0] counter_q, counter_d;
    logic [1:0]               rot;
    logic [1:0]               src [4];
    logic [DATA_WIDTH-1:0]    x_in [4];
    logic [DATA_WIDTH-1:0]    y_in [4];
    logic [DATA_WIDTH-1:0]    x_q [4];
    logic [DATA_WIDTH-1:0]    y_q [4];
    logic                     ctrl_q;

    assign x_in[0] = x_a_in;
    assign x_in[1] = x_b_in;
    assign x_in[2] = x_c_in;
    assign x_in[3] = x_d_in;
    assign y_in[0] = y_a_in;
    assign y_in[1] = y_b_in;
    assign y_in[2] = y_c_in;
    assign y_in[3] = y_d_in;

    // sel walks 00->01->11->10 in lockstep with the forward permutation.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        sel_d        = sel_q;
        proc_start_d = proc_start_q | ctrl_in;
        counter_d    = ctrl_in ? '0 : counter_q + 1'b1;
        if (!proc_start_q) begin
            sel_d = SEL_00;
        end else if (FLAG_COUNTER == 0 || (&counter_q)) begin
            sel_d = {sel_q[0], ~sel_q[1]};
        end
    end

    // Output channel k takes input channel (k + rot) mod 4.
    always_comb begin
        rot = 2'd0;
        case (sel_q)
            SEL_01:  rot = (LOWER != 0) ? 2'd3 : 2'd1;
            SEL_11:  rot = 2'd2;
            SEL_10:  rot = (LOWER != 0) ? 2'd1 : 2'd3;
            default: rot = 2'd0;
        endcase
        for (int k = 0; k < 4; k++) begin
            src[k] = rot + 2'(k);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst) begin
            sel_q        <= SEL_00;
            proc_start_q <= 1'b0;
            counter_q    <= '0;
        end else begin
            sel_q        <= sel_d;
            proc_start_q <= proc_start_d;
            counter_q    <= counter_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: data registers are reset so an aborted frame leaves nothing on the outputs.
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                x_q[k] <= '0;
                y_q[k] <= '0;
            end
            ctrl_q <= 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                x_q[k] <= x_in[src[k]];
                y_q[k] <= y_in[src[k]];
            end
            ctrl_q <= ctrl_in;
        end
    end

    assign x_a_out  = x_q[0];
    assign x_b_out  = x_q[1];
    assign x_c_out  = x_q[2];
    assign x_d_out  = x_q[3];
    assign y_a_out  = y_q[0];
    assign y_b_out  = y_q[1];
    assign y_c_out  = y_q[2];
    assign y_d_out  = y_q[3];
    assign ctrl_out = ctrl_q;

`ifdef PMT_INV_DBG_EN
    assign sel_dbg = sel_q;
`endif

endmodule

// File: tb/tb_pmt_inverse_com.sv
// Scoreboard bench for pmt_inverse_com: three instances (LOWER=0, LOWER=1, N=16 mode)
// share stimulus; expected restored channels are queued and checked by a monitor.
module tb_pmt_inverse_com;

    localparam int DW = 16;
    localparam int ND = 3;

    typedef struct packed {
        logic [ND-1:0][3:0][DW-1:0] x;
        logic [ND-1:0][3:0][DW-1:0] y;
        logic                       c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ctrl_in = 1'b0;
    logic [DW-1:0] xi [4];
    logic [DW-1:0] yi [4];
    wire  [ND-1:0][3:0][DW-1:0] xo;
    wire  [ND-1:0][3:0][DW-1:0] yo;
    wire  [ND-1:0] co;
`ifdef PMT_INV_DBG_EN
    wire  [ND-1:0][1:0] sd;
`endif

    exp_t q [$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // dut 0: defaults; dut 1: LOWER=1; dut 2: N=16 mode (sel advances every cycle)
    for (genvar g = 0; g < ND; g++) begin : g_dut
        pmt_inverse_com #(
            .DATA_WIDTH    (DW),
            .WIDTH_COUNTER ((g == 2) ? 1 : 2),
            .FLAG_COUNTER  ((g == 2) ? 0 : 1),
            .LOWER         ((g == 1) ? 1 : 0)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .ctrl_in  (ctrl_in),
            .x_a_in   (xi[0]),
            .y_a_in   (yi[0]),
            .x_b_in   (xi[1]),
            .y_b_in   (yi[1]),
            .x_c_in   (xi[2]),
            .y_c_in   (yi[2]),
            .x_d_in   (xi[3]),
            .y_d_in   (yi[3]),
            .x_a_out  (xo[g][0]),
            .y_a_out  (yo[g][0]),
            .x_b_out  (xo[g][1]),
            .y_b_out  (yo[g][1]),
            .x_c_out  (xo[g][2]),
            .y_c_out  (yo[g][2]),
            .x_d_out  (xo[g][3]),
            .y_d_out  (yo[g][3]),
            .ctrl_out (co[g])
`ifdef PMT_INV_DBG_EN
            ,
            .sel_dbg  (sd[g])
`endif
        );
    end

    task automatic check(input string name, input logic [2*4*DW:0] act, input logic [2*4*DW:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // sel in use during input cycle m of a frame (ctrl_in high at m=0, m<0 = idle)
    function automatic logic [1:0] exp_sel(input int g, input int m);
        int idx;
        if (m <= 0) return 2'b00;
        idx = (g == 2) ? ((m - 1) % 4) : (((m - 1) / 4) % 4);
        case (idx)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    // Source input channel for output channel k, written out from the restore tables.
    function automatic int src_of(input int lower, input logic [1:0] sel, input int k);
        int t [4];
        case (sel)
            2'b00: t = '{0, 1, 2, 3};
            2'b11: t = '{2, 3, 0, 1};
            2'b01: t = (lower != 0) ? '{3, 0, 1, 2} : '{1, 2, 3, 0};
            default: t = (lower != 0) ? '{1, 2, 3, 0} : '{3, 0, 1, 2};
        endcase
        return t[k];
    endfunction

    task automatic step(input logic c, input int m,
                        input logic [DW-1:0] va, input logic [DW-1:0] vb,
                        input logic [DW-1:0] vc, input logic [DW-1:0] vd);
        exp_t e;
        logic [1:0] s;
        @(negedge clk);
        ctrl_in = c;
        xi[0] = va; xi[1] = vb; xi[2] = vc; xi[3] = vd;
        for (int k = 0; k < 4; k++) yi[k] = xi[k] ^ 16'hA5A5;
        e = '0;
        e.c = c;
        for (int g = 0; g < ND; g++) begin
            s = exp_sel(g, m);
            for (int k = 0; k < 4; k++) begin
                e.x[g][k] = xi[src_of((g == 1) ? 1 : 0, s, k)];
                e.y[g][k] = yi[src_of((g == 1) ? 1 : 0, s, k)];
            end
        end
        q.push_back(e);
        @(posedge clk);
    endtask

    task automatic check_zero(input string name);
        for (int g = 0; g < ND; g++) begin
            check($sformatf("%s_dut%0d", name, g), {xo[g], yo[g], co[g]}, '0);
        end
    endtask

    task automatic frame(input int len);
        logic [DW-1:0] b;
        for (int m = 0; m < len; m++) begin
            b = DW'(m * 16'h0100);
            if (m == 5)       step(1'b0, m, 16'd1, 16'd2, 16'd3, 16'd4);
            else if (m == 14) step(1'b0, m, 16'h10, 16'h20, 16'h30, 16'h40);
            else              step(m == 0, m, b + 16'd1, b + 16'd2, b + 16'd3, b + 16'd4);
        end
    endtask

    // Monitor: one restored sample set per clock, one cycle after its inputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                for (int g = 0; g < ND; g++) begin
                    check($sformatf("data_dut%0d", g), {xo[g], yo[g], co[g]}, {e.x[g], e.y[g], e.c});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 4; k++) begin
            xi[k] = DW'(k + 1);
            yi[k] = DW'(k + 1);
        end
        #22;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // idle: identity map, ctrl_out low
        for (int i = 0; i < 3; i++) step(1'b0, -1, 16'd1, 16'd2, 16'd3, 16'd4);

        // full frame through the complete sel sequence and back to 00
        frame(21);

        // restart cleanly, then abort at cycle 6 between edges
        #2;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        frame(7);
        #3;
        rst = 1'b0;
        #1;
        check_zero("midframe_reset");
        @(negedge clk);
        rst = 1'b1;

        // after release sel must stay 00 until the next ctrl_in
        for (int i = 0; i < 6; i++) step(1'b0, -1, DW'(16'h0A00 + i), 16'h0B00, 16'h0C00, 16'h0D00);
        frame(10);

        @(posedge clk);
        @(posedge clk);
        #2;
        check("queue_drained", (2*4*DW+1)'(q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
